// File: rtl/fwd_pipe_slice_pkg.sv
// fwd_pipe_slice_pkg
//   Shared stream helpers for the forward pipeline slice.
//   clog2_min1(n): ceil(log2(n)) with a floor of 1, so a counter that must
//   represent values 0..n-1 always gets a legal, non-zero width.
package fwd_pipe_slice_pkg;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fwd_pipe_stage.sv
// fwd_pipe_stage
//   One forward register stage: a valid flag and a data word.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset (clears vld and dat)
//     flush       synchronous clear of vld (dat is kept)
//     load        stage is ready this cycle and takes whatever its source offers
//     src_vld     valid offered by the previous stage (or the upstream port)
//     src_dat     data offered by the previous stage (or the upstream port)
//     vld, dat    registered contents of this stage
module fwd_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= src_vld;
            // Data only moves with a real beat, so a bubble never clobbers
            // the word a stalled stage is still presenting.
            if (src_vld) begin
                dat <= src_dat;
            end
        end
    end

endmodule

// File: rtl/fwd_pipe_slice.sv
// fwd_pipe_slice
//   Forward-registered valid/ready pipeline slice with STAGES register
//   stages, bubble collapsing, flush and an occupancy count. Valid and data
//   are registered; ready is combinational.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     i_data      upstream data          i_valid  upstream valid
//     o_ready     upstream ready (combinational from i_ready and stage state)
//     o_data      downstream data        o_valid  downstream valid (registered)
//     i_ready     downstream ready
//     i_flush     synchronous discard of every held beat
//     o_count     number of stages holding a valid beat (0..STAGES)
//
//   Handshake: a beat moves across a port only on a clock edge where that
//   port's valid and ready are both 1. Once o_valid is 1, o_valid and o_data
//   hold until i_ready is 1, and o_valid never depends combinationally on
//   i_ready. o_ready may rise in the same cycle as i_ready.
module fwd_pipe_slice
    import fwd_pipe_slice_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int STAGES = 2,
    localparam int CW     = clog2_min1(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic             i_flush,
    output logic [CW-1:0]    o_count
);

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][WIDTH-1:0] dat;
    logic [STAGES-1:0]            rdy;
    logic                         full_ahead;
    logic                         acc;
    logic                         cons;
    logic [CW-1:0]                count;

    // rdy[k] = !vld[k] || rdy[k+1], with i_ready past the last stage.
    // Unrolled, stage k is ready unless it and every stage after it are
    // full while the downstream stalls; written that way the chain is a
    // single AND sweep with no self-referencing net.
    always_comb begin
        full_ahead = 1'b1;
        rdy        = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_ahead = full_ahead && vld[k];
            rdy[k]     = !full_ahead || i_ready;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             s_vld;
        logic [WIDTH-1:0] s_dat;

        if (k == 0) begin : g_src_in
            assign s_vld = i_valid;
            assign s_dat = i_data;
        end else begin : g_src_prev
            assign s_vld = vld[k-1];
            assign s_dat = dat[k-1];
        end

        fwd_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (i_flush),
            .load    (rdy[k]),
            .src_vld (s_vld),
            .src_dat (s_dat),
            .vld     (vld[k]),
            .dat     (dat[k])
        );
    end

    // Upstream is held off during flush and reset so nothing is accepted
    // into a pipe that is being cleared on the same edge.
    assign o_ready = rdy[0] && !i_flush && rst_n;
    assign o_valid = vld[STAGES-1];
    assign o_data  = dat[STAGES-1];

    assign acc  = i_valid && o_ready;
    assign cons = o_valid && i_ready;

    // Accept without a free stage only happens alongside a consume, so the
    // count stays within 0..STAGES and never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (i_flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(acc) - CW'(cons);
        end
    end

    assign o_count = count;

endmodule

// File: tb/tb_fwd_pipe_slice.sv
module tb_fwd_pipe_slice;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Directed DUT: WIDTH=8, STAGES=2
    logic        a_rst_n = 1'b0;
    logic [7:0]  a_data  = '0;
    logic        a_valid = 1'b0;
    logic        a_oready;
    logic [7:0]  a_odata;
    logic        a_ovalid;
    logic        a_iready = 1'b0;
    logic        a_flush  = 1'b0;
    logic [1:0]  a_count;

    // Random DUT: WIDTH=16, STAGES=3
    logic        b_rst_n = 1'b0;
    logic [15:0] b_data  = '0;
    logic        b_valid = 1'b0;
    logic        b_oready;
    logic [15:0] b_odata;
    logic        b_ovalid;
    logic        b_iready = 1'b0;
    logic        b_flush  = 1'b0;
    logic [1:0]  b_count;

    fwd_pipe_slice #(.WIDTH(8), .STAGES(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (a_rst_n),
        .i_data  (a_data),
        .i_valid (a_valid),
        .o_ready (a_oready),
        .o_data  (a_odata),
        .o_valid (a_ovalid),
        .i_ready (a_iready),
        .i_flush (a_flush),
        .o_count (a_count)
    );

    fwd_pipe_slice #(.WIDTH(16), .STAGES(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (b_rst_n),
        .i_data  (b_data),
        .i_valid (b_valid),
        .o_ready (b_oready),
        .o_data  (b_odata),
        .o_valid (b_ovalid),
        .i_ready (b_iready),
        .i_flush (b_flush),
        .o_count (b_count)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, let combinational outputs settle, then the
    // caller checks; the next call crosses the rising edge.
    task automatic drv_a(input logic rst, input logic v, input logic [7:0] d,
                         input logic r, input logic f);
        @(negedge clk);
        a_rst_n  = rst;
        a_valid  = v;
        a_data   = d;
        a_iready = r;
        a_flush  = f;
        #1;
    endtask

    // ---------------- scoreboard for the random phase ----------------
    // exp_q holds accepted-but-not-consumed beats, oldest first; pos_q holds
    // how far each beat has travelled (0 = input stage, 2 = output stage).
    // A beat advances one stage per edge unless the beat ahead of it is
    // stuck directly in front.
    logic [15:0] exp_q[$];
    int          pos_q[$];

    initial begin
        int          first_v;
        int          last_v;
        int          nv;
        logic [7:0]  expd;
        logic        rst, v, r, f, e_ready, e_valid, acc, cons;
        logic        prev_stall, prev_rst_low;
        logic [15:0] d, prev_dat;
        int          lim;

        // ---- reset ----
        drv_a(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
        check("rst_ready_low", a_oready, 0);
        drv_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rst_valid", a_ovalid, 0);
        check("rst_data", a_odata, 0);
        check("rst_count", a_count, 0);
        check("rst_ready", a_oready, 1);

        // ---- streaming 0x01..0x10 ----
        first_v = -1; last_v = -1; nv = 0; expd = 8'h01;
        for (int c = 0; c < 20; c++) begin
            drv_a(1'b1, (c < 16), 8'(c + 1), 1'b1, 1'b0);
            check("stream_ready", a_oready, 1);
            if (a_ovalid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                check("stream_data", a_odata, expd);
                expd = expd + 8'd1;
                nv++;
            end
        end
        check("stream_first", first_v, 2);
        check("stream_beats", nv, 16);
        check("stream_last", last_v, 17);

        // ---- stall collapse ----
        drv_a(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        check("stall_rdy0", a_oready, 1);
        check("stall_cnt0", a_count, 0);
        drv_a(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        check("stall_rdy1", a_oready, 1);
        check("stall_cnt1", a_count, 1);
        drv_a(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
        check("stall_rdy_full", a_oready, 0);
        check("stall_cnt2", a_count, 2);
        check("stall_valid", a_ovalid, 1);
        check("stall_data", a_odata, 8'hA1);
        drv_a(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
        check("stall_hold", a_odata, 8'hA1);
        check("stall_hold_cnt", a_count, 2);
        drv_a(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
        check("stall_release_rdy", a_oready, 1);
        check("stall_out_a1", a_odata, 8'hA1);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("stall_out_a2", a_odata, 8'hA2);
        check("stall_cnt_a2", a_count, 2);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("stall_out_a3", a_odata, 8'hA3);
        check("stall_cnt_a3", a_count, 1);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("stall_empty", a_ovalid, 0);
        check("stall_cnt_end", a_count, 0);

        // ---- simultaneous accept/consume at full ----
        drv_a(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
        drv_a(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drv_a(1'b1, 1'b1, 8'(8'hB3 + i), 1'b1, 1'b0);
            check("full_rdy", a_oready, 1);
            check("full_cnt", a_count, 2);
            check("full_data", a_odata, 8'(8'hB1 + i));
        end
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("full_cnt_after", a_count, 2);
        check("full_b5", a_odata, 8'hB5);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("full_b6", a_odata, 8'hB6);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("full_drained", a_ovalid, 0);

        // ---- flush ----
        drv_a(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
        drv_a(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
        drv_a(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
        check("flush_rdy", a_oready, 0);
        check("flush_cnt_pre", a_count, 2);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("flush_valid", a_ovalid, 0);
        check("flush_cnt", a_count, 0);
        check("flush_rdy_after", a_oready, 1);
        for (int i = 0; i < 3; i++) begin
            drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            check("flush_gone", a_ovalid, 0);
        end

        // ---- reset mid-operation ----
        drv_a(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0);
        drv_a(1'b1, 1'b1, 8'hD2, 1'b0, 1'b0);
        drv_a(1'b0, 1'b1, 8'hD3, 1'b0, 1'b0);
        check("mrst_rdy_low", a_oready, 0);
        check("mrst_cnt_pre", a_count, 2);
        drv_a(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        check("mrst_valid", a_ovalid, 0);
        check("mrst_data", a_odata, 0);
        check("mrst_cnt", a_count, 0);
        check("mrst_rdy", a_oready, 1);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("mrst_lat1", a_ovalid, 0);
        check("mrst_cnt1", a_count, 1);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("mrst_lat2", a_ovalid, 1);
        check("mrst_55", a_odata, 8'h55);
        drv_a(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // ---- random valid/ready on the 3-stage, 16-bit instance ----
        prev_stall = 1'b0; prev_dat = '0; prev_rst_low = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            rst = (c < 2) ? 1'b0 : ($urandom_range(0, 999) != 0);
            v   = ($urandom_range(0, 99) < 60);
            d   = 16'($urandom);
            r   = ($urandom_range(0, 99) < 55);
            f   = ($urandom_range(0, 99) == 0);

            @(negedge clk);
            b_rst_n  = rst;
            b_valid  = v;
            b_data   = d;
            b_iready = r;
            b_flush  = f;
            #1;

            e_ready = rst && !f && ((exp_q.size() < 3) || r);
            e_valid = (exp_q.size() > 0) && (pos_q[0] == 2);

            check("rnd_ready", b_oready, e_ready);
            check("rnd_valid", b_ovalid, e_valid);
            check("rnd_count", b_count, exp_q.size());
            if (e_valid) check("rnd_data", b_odata, exp_q[0]);
            if (prev_stall) begin
                check("rnd_hold_valid", b_ovalid, 1);
                check("rnd_hold_data", b_odata, prev_dat);
            end
            if (prev_rst_low && rst) check("rnd_rst_data", b_odata, 0);

            prev_stall   = e_valid && !r && rst && !f;
            prev_dat     = e_valid ? exp_q[0] : 16'h0;
            prev_rst_low = !rst;
            acc          = v && e_ready;
            cons         = e_valid && r;

            @(posedge clk);
            if (!rst || f) begin
                exp_q.delete();
                pos_q.delete();
            end else begin
                if (cons) begin
                    void'(exp_q.pop_front());
                    void'(pos_q.pop_front());
                end
                for (int i = 0; i < pos_q.size(); i++) begin
                    lim = (i == 0) ? 2 : pos_q[i-1] - 1;
                    pos_q[i] = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
                end
                if (acc) begin
                    exp_q.push_back(d);
                    pos_q.push_back(0);
                end
            end
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
